apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, APB data width.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 The block SHALL expose parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 The block SHALL expose parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports named PCLK and PRESETn.
REQ-006 PCLK  in  1  system clock, all state on rising edge.
REQ-007 PRESETn  in  1  asynchronous active-low reset.
REQ-008 cmd_valid  in  1 / cmd_ready  out  1  command handshake.
REQ-009 cmd_write  in  1 / cmd_addr  in  ADDR_WIDTH / cmd_wdata  in  DATA_WIDTH / cmd_strb  in  STRB_WIDTH  command payload.
REQ-010 rsp_valid  out  1 / rsp_ready  in  1  response handshake.
REQ-011 rsp_rdata  out  DATA_WIDTH / rsp_err  out  1  response payload.
REQ-012 PSEL, PENABLE, PWRITE  out  1 each / PADDR  out  ADDR_WIDTH / PWDATA  out  DATA_WIDTH / PSTRB  out  STRB_WIDTH  APB request.
REQ-013 PREADY  in  1 / PRDATA  in  DATA_WIDTH / PSLVERR  in  1  APB completion.

Function
REQ-014 The FSM SHALL use one-hot states IDLE, SETUP, ACCESS, RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready, with payload registered on that edge.
REQ-016 An accepted aligned command (cmd_addr[1:0]==0) SHALL move IDLE->SETUP; a misaligned one SHALL move IDLE->RESP with rsp_err=1, rsp_rdata=0, and no APB activity.
REQ-017 SETUP SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then move to ACCESS.
REQ-018 ACCESS SHALL drive PSEL=1 and PENABLE=1, and remain there while PREADY=0.
REQ-019 PADDR, PWRITE, PWDATA and PSTRB SHALL be held stable from SETUP through the final ACCESS cycle.
REQ-020 PSTRB SHALL equal cmd_strb for writes and 0 for reads; PWDATA SHALL be 0 for reads.
REQ-021 On ACCESS with PREADY=1, the block SHALL capture PRDATA (reads; 0 for writes) and PSLVERR into rsp_rdata/rsp_err, then move to RESP.
REQ-022 A wait counter SHALL count consecutive ACCESS cycles with PREADY=0 and clear on entering SETUP.
REQ-023 On the TIMEOUT_CYCLES-th such cycle, the block SHALL abort to RESP with rsp_err=1 and rsp_rdata=0.
REQ-024 RESP SHALL drive rsp_valid=1, PSEL=0 and PENABLE=0, holding rsp_rdata/rsp_err stable until rsp_ready=1, then move to IDLE.
REQ-025 Minimum latency SHALL be rsp_valid asserted 3 cycles after command acceptance (0 wait states); a new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-026 PSEL and PENABLE SHALL be 0 in IDLE and RESP; PENABLE=1 SHALL never occur with PSEL=0.

Reset
REQ-027 PRESETn=0 SHALL immediately (asynchronously) force state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, cmd_ready=0.
REQ-028 cmd_ready SHALL rise on the first PCLK edge after PRESETn deasserts; an in-flight transfer SHALL be dropped without a response.

Verification
REQ-029 Write 0xA5A5_5A5A to 0x04, strb 0xF, PREADY tied 1 -> one SETUP cycle, one ACCESS cycle, PSTRB=0xF, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-030 Read 0x1C, PREADY=0 for 3 ACCESS cycles then 1 with PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-031 Write 0x40 with PSLVERR=1 on the PREADY cycle -> rsp_err=1; next command accepted after rsp_ready.
REQ-032 PREADY held 0 -> abort after 16 ACCESS cycles, PSEL drops, rsp_err=1, rsp_rdata=0.
REQ-033 Read 0x06 (misaligned) -> PSEL never asserted, rsp_valid 1 cycle after accept, rsp_err=1.
REQ-034 PRESETn pulsed low mid-ACCESS -> PSEL/PENABLE 0 without a clock edge, no rsp_valid, cmd_ready=1 on first edge after release; rsp_valid held 5 cycles with rsp_ready=0 keeps payload stable.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Converts a single-outstanding command/response handshake into APB
//   transfers (SETUP -> ACCESS -> RESP). Misaligned commands are answered
//   with an error and never reach the bus. ACCESS is bounded by a wait
//   counter, so a hung slave produces an error response.
// Ports
//   PCLK, PRESETn                  clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write/addr/wdata/strb      command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB   APB request
//   PREADY/PRDATA/PSLVERR          APB completion
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    RESP   = 4'b1000
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             live;     // low until the first edge after reset release
  logic             accept;
  logic             aligned;
  logic             timeout;

  assign aligned   = (cmd_addr[1:0] == 2'b00);
  assign cmd_ready = (state == IDLE) && live;
  assign accept    = cmd_valid && cmd_ready;
  // Last tolerated wait cycle: this PREADY=0 cycle is the TIMEOUT_CYCLES-th.
  assign timeout   = (state == ACCESS) && !PREADY &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Bus controls decode straight from state, so reset clears them without an edge.
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = aligned ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      live      <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        if (aligned) begin
          // Bus payload is loaded only for transfers that will reach APB and
          // then stays put until the next accepted command.
          PADDR    <= cmd_addr;
          PWRITE   <= cmd_write;
          PWDATA   <= cmd_write ? cmd_wdata : '0;
          PSTRB    <= cmd_write ? cmd_strb  : '0;
          wait_cnt <= '0;
        end else begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          rsp_rdata <= PWRITE ? '0 : PRDATA;
          rsp_err   <= PSLVERR;
        end else if (timeout) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: PREADY rises after slv_waits ACCESS cycles with PREADY low.
  int          slv_waits = 0;
  int          acc_cnt   = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  always @(posedge PCLK) acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
  assign PREADY  = (acc_cnt >= slv_waits);
  assign PRDATA  = slv_rdata;
  assign PSLVERR = slv_err;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t exp_q[$];

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on every response handshake; also watches APB legality.
  always @(negedge PCLK) begin
    if (PRESETn && PENABLE && !PSEL) begin
      errs++;
      $display("FAIL penable_wo_psel: got PENABLE=1 PSEL=0 expected PSEL=1");
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
      else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("sb_rdata", rsp_rdata, e.rdata);
        chk("sb_err", rsp_err, e.err);
      end
    end
  end

  // One command end to end. exp_acc = expected ACCESS cycles (0: no APB).
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input logic [31:0] prd,
                        input logic perr, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_acc, input int hold);
    int n, lat, setups, accs;
    logic bad;
    rsp_t e;
    @(posedge PCLK); #1;
    slv_waits = waits; slv_rdata = prd; slv_err = perr;
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    @(negedge PCLK);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
    chk("accept_ready", cmd_ready, 1);
    e.rdata = exp_rdata; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    lat = 0; setups = 0; accs = 0; bad = 1'b0;
    do begin
      @(negedge PCLK); lat++;
      if (!rsp_valid && PSEL) begin
        if (PENABLE) accs++; else setups++;
        if (PADDR !== addr || PWRITE !== wr || PSTRB !== (wr ? strb : 4'h0) ||
            PWDATA !== (wr ? wdata : 32'h0)) bad = 1'b1;
      end
    end while (!rsp_valid && lat < 60);
    chk("rsp_latency", lat, exp_lat);
    chk("setup_cycles", setups, (exp_acc == 0) ? 0 : 1);
    chk("access_cycles", accs, exp_acc);
    chk("apb_payload_stable", bad, 0);
    if (hold > 0) begin
      repeat (hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, exp_rdata);
        chk("hold_err", rsp_err, exp_err);
        @(negedge PCLK);
      end
      @(posedge PCLK); #1;
      rsp_ready = 1'b1;
      @(negedge PCLK);
    end
    @(negedge PCLK);
    chk("next_cmd_ready", cmd_ready, 1);
    chk("rsp_dropped", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp_err", rsp_err, 0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst_ready_still_low", cmd_ready, 0);
    @(negedge PCLK);
    chk("ready_after_release", cmd_ready, 1);

    //     wr  addr          wdata         strb  waits prdata        perr exp_rdata     err lat acc hold
    do_cmd(1, 32'h04,       32'hA5A55A5A, 4'hF, 0,    32'hFFFFFFFF, 0,   32'h0,        0,  3,  1,  0);
    do_cmd(0, 32'h1C,       32'h0,        4'h0, 3,    32'h12345678, 0,   32'h12345678, 0,  6,  4,  0);
    do_cmd(1, 32'h40,       32'h11223344, 4'h3, 0,    32'hFFFFFFFF, 1,   32'h0,        1,  3,  1,  0);
    do_cmd(0, 32'h80,       32'h0,        4'h0, 1000, 32'h55555555, 0,   32'h0,        1,  18, 16, 0);
    do_cmd(0, 32'h06,       32'h0,        4'h0, 0,    32'h55555555, 0,   32'h0,        1,  1,  0,  0);
    do_cmd(1, 32'h101,      32'h77777777, 4'hF, 0,    32'h55555555, 0,   32'h0,        1,  1,  0,  0);
    do_cmd(0, 32'h08,       32'h0,        4'h0, 0,    32'hCAFEF00D, 0,   32'hCAFEF00D, 0,  3,  1,  5);
    do_cmd(0, 32'h2C,       32'h0,        4'h0, 2,    32'hDEADBEEF, 1,   32'hDEADBEEF, 1,  5,  3,  0);

    // Reset pulse in the middle of a stalled ACCESS: transfer dropped silently.
    begin
      int n;
      @(posedge PCLK); #1;
      slv_waits = 1000; slv_err = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
      @(negedge PCLK);
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge PCLK); n++; end
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      n = 0;
      do begin @(negedge PCLK); n++; end while (!PENABLE && n < 20);
      chk("mid_access_reached", PENABLE, 1);
      @(negedge PCLK);
      #1 PRESETn = 1'b0;
      #1;
      chk("async_psel", PSEL, 0);
      chk("async_penable", PENABLE, 0);
      chk("async_cmd_ready", cmd_ready, 0);
      chk("async_paddr", PADDR, 0);
      #1 PRESETn = 1'b1;
      #1;
      chk("release_ready_low", cmd_ready, 0);
      @(negedge PCLK);
      chk("release_ready_high", cmd_ready, 1);
      repeat (4) begin
        chk("no_rsp_after_reset", rsp_valid, 0);
        @(negedge PCLK);
      end
    end
    slv_waits = 0;

    do_cmd(1, 32'h04,       32'h0BADF00D, 4'h5, 0,    32'hFFFFFFFF, 0,   32'h0,        0,  3,  1,  0);

    repeat (3) @(negedge PCLK);
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
